lsu_stb_rdctl: RTL
==================

Name: lsu_stb_rdctl

Overview:
- Read/drain side of the per-thread 8-entry store buffer (STB). Consumes the per-entry state captured at store write time (va[7:6], rq_type[2:1], rmo).
- Tracks each entry's lifecycle and selects the oldest unissued entry. Issues it to the PCX arbiter with a req/gnt handshake and frees entries on CPX store-ack.
- Enforces TSO ordering: a non-RMO store issues only when no store is outstanding. RMO stores may issue with stores outstanding.

Parameters:
- NENT, 8, number of STB entries (power of 2).
- PTRW, 3, entry index width (log2 NENT).

Ports:
- rclk  in  1  core clock
- arst  in  1  asynchronous reset, active-high
- stb_wr_en_l  in  NENT  per-entry write strobe, active-low; writer asserts at most one bit per cycle
- stb_state_si  in  2*NENT  flattened va[7:6]; entry i at [2i+1:2i]
- stb_state_rtype  in  2*NENT  flattened rq_type[2:1]; entry i at [2i+1:2i]
- stb_state_rmo  in  NENT  per-entry RMO flag
- pcx_gnt  in  1  arbiter grant for the current request
- cpx_st_ack  in  1  store-ack valid
- cpx_st_ack_ent  in  PTRW  entry index being acked
- pcx_req  out  1  store issue request
- pcx_ent  out  PTRW  entry index being requested
- pcx_si  out  2  va[7:6] of the requested entry
- pcx_rtype  out  2  rq_type of the requested entry
- pcx_rmo  out  1  RMO flag of the requested entry
- stb_vld  out  NENT  entry non-empty (VALID or ISSUED)
- stb_empty  out  1  all entries EMPTY
- stb_full  out  1  all entries non-empty
- stb_rptr  out  PTRW  oldest unissued entry pointer
- stb_outstd_cnt  out  PTRW+1  count of ISSUED entries
- stb_wr_err  out  1  one-cycle pulse: write to a non-EMPTY entry

Behaviour:
- Clock and reset: single clock rclk. Reset arst is asynchronous and active-high.
- Reset values: every entry EMPTY; rptr=0; outstd_cnt=0; issue FSM in IDLE; pcx_req=0; pcx_ent/si/rtype/rmo=0; stb_vld=0; stb_empty=1; stb_full=0; stb_wr_err=0.
  - Reset asserted mid-request drops pcx_req immediately; no grant completes.
- Entry state per entry: EMPTY, VALID, ISSUED.
  - EMPTY->VALID: stb_wr_en_l[i]=0.
  - VALID->ISSUED: pcx_gnt while pcx_ent=i.
  - ISSUED->EMPTY: cpx_st_ack with cpx_st_ack_ent=i.
- Write to a VALID/ISSUED entry: entry unchanged; stb_wr_err=1 the next cycle.
- Ack to an entry that is not ISSUED: ignored, no state change.
- Eligible: state[rptr]==VALID AND (stb_state_rmo[rptr]==1 OR outstd_cnt==0).
- Issue FSM:
  - IDLE: if eligible, register pcx_ent=rptr and the si/rtype/rmo fields of entry rptr, set pcx_req=1, go to REQ. Otherwise stay in IDLE.
  - REQ: hold pcx_req and all fields stable until pcx_gnt. On gnt: entry -> ISSUED, rptr <= rptr+1 (wrap 7->0), pcx_req=0, go to IDLE.
  - Result: one idle cycle minimum between consecutive requests.
- Latency: a write in cycle N makes the entry VALID at N+1. pcx_req rises no earlier than N+2.
- outstd_cnt: +1 on gnt, -1 on valid ack. Gnt and valid ack in the same cycle leave it unchanged. Width PTRW+1; range 0..NENT; never wraps.
- Ack to an entry in the same cycle as its grant: ignored, because the entry is not yet ISSUED.
- Write to entry rptr in the same cycle the FSM is IDLE: the entry is not seen until the next cycle.
- stb_vld, stb_empty, stb_full: decoded from registered entry state; no extra latency beyond the state flops.
- Field inputs are sampled only at the IDLE->REQ transition. Later changes to the inputs do not affect the request in flight.

Decomposition:
- Shared package lsu_stb_pkg: entry-state encoding constants (EMPTY=2'b00, VALID=2'b01, ISSUED=2'b10), issue FSM state encoding, NENT/PTRW defaults.
- Sub-module lsu_stb_rd_ent: one per entry. Holds the 2-bit state flop and the write/grant/ack transition logic, plus the wr_err contribution. Instantiated NENT times; the parent holds rptr, the counter and the FSM.

Test Plan:
- Reset then write entry 0 (si=2'b10, rtype=2'b01, rmo=0) -> pcx_req=1 two cycles later with pcx_ent=0, pcx_si=2'b10, pcx_rtype=2'b01. Gnt -> stb_rptr=1, stb_outstd_cnt=1.
- TSO: write entries 0 and 1 (rmo=0); grant 0 -> no request for 1 until ack(ent=0). Ack -> request for entry 1 two cycles later.
- RMO: entries 0..2 with rmo=1; grant each -> three requests issue without acks; stb_outstd_cnt=3. Acks arriving out of order (2, 0, 1) -> count 0 and stb_empty=1.
- Fill all 8 entries -> stb_full=1. Write entry 3 again -> stb_wr_err pulses for one cycle and entry 3 is unchanged. Drain through 7 -> rptr wraps to 0.
- Hold pcx_gnt=0 for 5 cycles while changing stb_state_si -> pcx_req and all fields stay stable. Gnt + ack(other entry) in the same cycle -> stb_outstd_cnt unchanged.
- Assert arst while pcx_req=1 -> pcx_req=0 immediately; all outputs at reset values; a grant arriving in that cycle is ignored.

Source files
------------

// File: rtl/lsu_stb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stb_pkg
// Description : Shared constants for the store-buffer read/drain controller:
//               entry-state encoding, issue FSM encoding and default sizing.
// Revision    : 1.0  initial release
// ============================================================================
package lsu_stb_pkg;

    // Default buffer geometry
    localparam int c_NENT = 8;
    localparam int c_PTRW = 3;

    // Per-entry lifecycle encoding
    localparam logic [1:0] c_ENT_EMPTY  = 2'b00;
    localparam logic [1:0] c_ENT_VALID  = 2'b01;
    localparam logic [1:0] c_ENT_ISSUED = 2'b10;

    // Issue FSM encoding
    localparam logic [0:0] c_ISS_IDLE = 1'b0;
    localparam logic [0:0] c_ISS_REQ  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/lsu_stb_rd_ent.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stb_rd_ent
// Description : Lifecycle tracker for one store-buffer entry
//               (EMPTY -> VALID -> ISSUED -> EMPTY) plus write-error flag.
// Revision    : 1.0  initial release
// ============================================================================
module lsu_stb_rd_ent
    import lsu_stb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr,
    input  logic       i_gnt,
    input  logic       i_ack,
    output logic [1:0] o_state,
    output logic       o_wr_err
);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_wr_err;

    // Each event only acts in the one state it applies to, so the three
    // transitions can never collide.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ENT_EMPTY:  if (i_wr)  w_state_next = c_ENT_VALID;
            c_ENT_VALID:  if (i_gnt) w_state_next = c_ENT_ISSUED;
            c_ENT_ISSUED: if (i_ack) w_state_next = c_ENT_EMPTY;
            default:                 w_state_next = c_ENT_EMPTY;
        endcase
    end

    // State flop and registered write-to-occupied-entry flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ENT_EMPTY;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_wr_err <= i_wr && (r_state != c_ENT_EMPTY);
        end
    end

    assign o_state  = r_state;
    assign o_wr_err = r_wr_err;

endmodule
`default_nettype wire

// File: rtl/lsu_stb_rdctl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stb_rdctl
// Description : Store-buffer drain control: picks the oldest unissued entry,
//               requests the PCX arbiter with TSO/RMO ordering, retires on ack.
// Revision    : 1.0  initial release
// ============================================================================
module lsu_stb_rdctl
    import lsu_stb_pkg::*;
#(
    parameter int NENT = c_NENT,
    parameter int PTRW = c_PTRW
) (
    input  logic                rclk,
    input  logic                arst,
    input  logic [NENT-1:0]     stb_wr_en_l,
    input  logic [2*NENT-1:0]   stb_state_si,
    input  logic [2*NENT-1:0]   stb_state_rtype,
    input  logic [NENT-1:0]     stb_state_rmo,
    input  logic                pcx_gnt,
    input  logic                cpx_st_ack,
    input  logic [PTRW-1:0]     cpx_st_ack_ent,
    output logic                pcx_req,
    output logic [PTRW-1:0]     pcx_ent,
    output logic [1:0]          pcx_si,
    output logic [1:0]          pcx_rtype,
    output logic                pcx_rmo,
    output logic [NENT-1:0]     stb_vld,
    output logic                stb_empty,
    output logic                stb_full,
    output logic [PTRW-1:0]     stb_rptr,
    output logic [PTRW:0]       stb_outstd_cnt,
    output logic                stb_wr_err
);

    logic [1:0]       w_ent_state [NENT];
    logic [NENT-1:0]  w_wr_err;
    logic [0:0]       r_iss_state;
    logic [0:0]       w_iss_next;
    logic             w_load;
    logic             w_gnt_fire;
    logic             w_ack_ok;
    logic             w_eligible;
    logic [PTRW-1:0]  r_rptr;
    logic [PTRW:0]    r_outstd_cnt;
    logic [PTRW-1:0]  r_pcx_ent;
    logic [1:0]       r_pcx_si;
    logic [1:0]       r_pcx_rtype;
    logic             r_pcx_rmo;

    // A grant only counts while a request is actually up; an ack only counts
    // against an entry already ISSUED (so an ack racing its own grant is dropped).
    assign w_gnt_fire = (r_iss_state == c_ISS_REQ) && pcx_gnt;
    assign w_ack_ok   = cpx_st_ack && (w_ent_state[cpx_st_ack_ent] == c_ENT_ISSUED);
    assign w_eligible = (w_ent_state[r_rptr] == c_ENT_VALID) &&
                        (stb_state_rmo[r_rptr] || (r_outstd_cnt == '0));

    for (genvar gi = 0; gi < NENT; gi++) begin : g_ent
        lsu_stb_rd_ent u_ent (
            .clk      (rclk),
            .rst      (arst),
            .i_wr     (~stb_wr_en_l[gi]),
            .i_gnt    (w_gnt_fire && (r_pcx_ent == PTRW'(gi))),
            .i_ack    (cpx_st_ack && (cpx_st_ack_ent == PTRW'(gi))),
            .o_state  (w_ent_state[gi]),
            .o_wr_err (w_wr_err[gi])
        );
        assign stb_vld[gi] = (w_ent_state[gi] != c_ENT_EMPTY);
    end

    // Issue FSM next-state: launch from IDLE when eligible, return on grant
    always_comb begin
        w_iss_next = r_iss_state;
        w_load     = 1'b0;
        case (r_iss_state)
            c_ISS_IDLE: begin
                if (w_eligible) begin
                    w_iss_next = c_ISS_REQ;
                    w_load     = 1'b1;
                end
            end
            c_ISS_REQ: begin
                if (pcx_gnt) w_iss_next = c_ISS_IDLE;
            end
            default: w_iss_next = c_ISS_IDLE;
        endcase
    end

    // Issue FSM state register
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) r_iss_state <= c_ISS_IDLE;
        else      r_iss_state <= w_iss_next;
    end

    // Request fields are captured once at launch and held through the handshake
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            r_pcx_ent   <= '0;
            r_pcx_si    <= '0;
            r_pcx_rtype <= '0;
            r_pcx_rmo   <= 1'b0;
        end else if (w_load) begin
            r_pcx_ent   <= r_rptr;
            r_pcx_si    <= stb_state_si[{r_rptr, 1'b0} +: 2];
            r_pcx_rtype <= stb_state_rtype[{r_rptr, 1'b0} +: 2];
            r_pcx_rmo   <= stb_state_rmo[r_rptr];
        end
    end

    // Read pointer advances on each grant; natural wrap since NENT is 2^PTRW
    always_ff @(posedge rclk or posedge arst) begin
        if (arst)            r_rptr <= '0;
        else if (w_gnt_fire) r_rptr <= r_rptr + PTRW'(1);
    end

    // Outstanding-store count: simultaneous grant and ack cancel out
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            r_outstd_cnt <= '0;
        end else begin
            case ({w_gnt_fire, w_ack_ok})
                2'b10:   r_outstd_cnt <= r_outstd_cnt + (PTRW+1)'(1);
                2'b01:   r_outstd_cnt <= r_outstd_cnt - (PTRW+1)'(1);
                default: r_outstd_cnt <= r_outstd_cnt;
            endcase
        end
    end

    assign pcx_req        = (r_iss_state == c_ISS_REQ);
    assign pcx_ent        = r_pcx_ent;
    assign pcx_si         = r_pcx_si;
    assign pcx_rtype      = r_pcx_rtype;
    assign pcx_rmo        = r_pcx_rmo;
    assign stb_empty      = ~|stb_vld;
    assign stb_full       = &stb_vld;
    assign stb_rptr       = r_rptr;
    assign stb_outstd_cnt = r_outstd_cnt;
    assign stb_wr_err     = |w_wr_err;

endmodule
`default_nettype wire
